// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver with frame-synchronous capture, leading-zero
// blanking, per-digit decimal points, PWM brightness and selectable pin polarity.
module seven_seg_scanner #(
    parameter int NUM_DIGITS         = 4,
    parameter int DIGIT_PERIOD_LOG2  = 17,
    parameter int BRIGHTNESS_BITS    = 4,
    parameter bit SEGMENT_ACTIVE_LOW = 1,
    parameter bit DIGIT_ACTIVE_LOW   = 1
) (
    input  logic                       clock,
    input  logic                       notReset,
    input  logic                       enable,
    input  logic [4*NUM_DIGITS-1:0]    data,
    input  logic [NUM_DIGITS-1:0]      dpMask,
    input  logic                       blankLeadingZeros,
    input  logic [BRIGHTNESS_BITS-1:0] brightness,
    output logic [7:0]                 segment,
    output logic [NUM_DIGITS-1:0]      digit,
    output logic                       frameTick
);

    localparam int POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] SEG_OFF = SEGMENT_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_DIGITS - 1);

    logic [DIGIT_PERIOD_LOG2-1:0] tick_count;
    logic [POS_W-1:0]             position;

    logic [4*NUM_DIGITS-1:0]      shadow_data;
    logic [NUM_DIGITS-1:0]        shadow_dp;
    logic                         shadow_blank;
    logic [BRIGHTNESS_BITS-1:0]   shadow_bright;

    logic                         frame_start;
    logic [4*NUM_DIGITS-1:0]      eff_data;
    logic [NUM_DIGITS-1:0]        eff_dp;
    logic                         eff_blank;
    logic [BRIGHTNESS_BITS-1:0]   eff_bright;

    logic [3:0]                   cur_nibble;
    logic                         cur_dp;
    logic                         cur_blanked;
    logic [NUM_DIGITS-1:0]        blank_vec;
    logic [BRIGHTNESS_BITS-1:0]   phase;
    logic                         lit;
    logic [7:0]                   seg_on;
    logic [NUM_DIGITS-1:0]        dig_on;
    logic [7:0]                   segment_next;
    logic [NUM_DIGITS-1:0]        digit_next;

    function automatic logic [6:0] hex_font(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h3F;
            4'h1:    pattern = 7'h06;
            4'h2:    pattern = 7'h5B;
            4'h3:    pattern = 7'h4F;
            4'h4:    pattern = 7'h66;
            4'h5:    pattern = 7'h6D;
            4'h6:    pattern = 7'h7D;
            4'h7:    pattern = 7'h07;
            4'h8:    pattern = 7'h7F;
            4'h9:    pattern = 7'h6F;
            4'hA:    pattern = 7'h77;
            4'hB:    pattern = 7'h7C;
            4'hC:    pattern = 7'h39;
            4'hD:    pattern = 7'h5E;
            4'hE:    pattern = 7'h79;
            default: pattern = 7'h71;
        endcase
        return pattern;
    endfunction

    // On the capture cycle the live inputs bypass the shadows so the first
    // digit of a new frame already shows the new values.
    assign frame_start = (tick_count == '0) && (position == '0);
    assign eff_data    = frame_start ? data              : shadow_data;
    assign eff_dp      = frame_start ? dpMask            : shadow_dp;
    assign eff_blank   = frame_start ? blankLeadingZeros : shadow_blank;
    assign eff_bright  = frame_start ? brightness        : shadow_bright;

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (POS_W'(i) == position) begin
                cur_nibble = eff_data[4*i +: 4];
                cur_dp     = eff_dp[i];
            end
        end
    end

    // Scan from the most significant position down; a position is blank while
    // it and everything above it is zero. Position 0 always shows.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (eff_data[4*i +: 4] == 4'h0);
            blank_vec[i] = eff_blank && all_zero && (i != 0);
        end
    end

    always_comb begin
        cur_blanked = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (POS_W'(i) == position) begin
                cur_blanked = blank_vec[i];
            end
        end
    end

    assign phase = tick_count[DIGIT_PERIOD_LOG2-1 -: BRIGHTNESS_BITS];
    assign lit   = enable && (phase <= eff_bright);

    always_comb begin
        seg_on       = {cur_dp, (cur_blanked ? 7'h00 : hex_font(cur_nibble))};
        dig_on       = NUM_DIGITS'(1) << position;
        segment_next = SEG_OFF;
        digit_next   = DIG_OFF;
        if (lit) begin
            segment_next = SEGMENT_ACTIVE_LOW ? ~seg_on : seg_on;
            digit_next   = DIGIT_ACTIVE_LOW   ? ~dig_on : dig_on;
        end
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            tick_count <= '0;
            position   <= '0;
        end else begin
            tick_count <= tick_count + 1'b1;
            if (tick_count == '1) begin
                position <= (position == LAST_POS) ? '0 : position + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            shadow_data   <= '0;
            shadow_dp     <= '0;
            shadow_blank  <= 1'b0;
            shadow_bright <= '0;
        end else if (frame_start) begin
            shadow_data   <= data;
            shadow_dp     <= dpMask;
            shadow_blank  <= blankLeadingZeros;
            shadow_bright <= brightness;
        end
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            segment   <= SEG_OFF;
            digit     <= DIG_OFF;
            frameTick <= 1'b0;
        end else begin
            segment   <= segment_next;
            digit     <= digit_next;
            frameTick <= frame_start;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed scenarios plus random input churn,
// checked every cycle against a frame-level model of the display.
module tb_seven_seg_scanner;

    localparam int N = 4;
    localparam int P = 4;
    localparam int B = 2;

    logic        clock = 1'b0;
    logic        notReset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] data = 16'h0;
    logic [3:0]  dpMask = 4'h0;
    logic        blankLeadingZeros = 1'b0;
    logic [1:0]  brightness = 2'd0;
    logic [7:0]  segment;
    logic [3:0]  digit;
    logic        frameTick;

    seven_seg_scanner #(
        .NUM_DIGITS(N), .DIGIT_PERIOD_LOG2(P), .BRIGHTNESS_BITS(B),
        .SEGMENT_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock), .notReset(notReset), .enable(enable), .data(data),
        .dpMask(dpMask), .blankLeadingZeros(blankLeadingZeros),
        .brightness(brightness), .segment(segment), .digit(digit),
        .frameTick(frameTick)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Model: cycles since reset release; what the display shows is a function
    // of that count and the inputs captured at the last frame start.
    logic [6:0]  font [16];
    int          cyc = 0;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic        m_blank;
    logic [1:0]  m_bright;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_ft;

    task automatic model_edge();
        int tick, pos;
        logic blank, on;
        logic [7:0] segs;
        tick = cyc % 16;
        pos  = (cyc / 16) % 4;
        exp_ft = (cyc % 64) == 0;
        if (exp_ft) begin
            m_data = data; m_dp = dpMask; m_blank = blankLeadingZeros; m_bright = brightness;
        end
        blank = m_blank && pos > 0 && ((m_data >> (4 * pos)) == 16'h0);
        on    = enable && ((tick / 4) <= int'(m_bright));
        segs  = {m_dp[pos], (blank ? 7'h00 : font[m_data[4*pos +: 4]])};
        exp_seg = on ? ~segs : 8'hFF;
        exp_dig = on ? ~(4'b0001 << pos) : 4'hF;
        cyc++;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("segment", segment, exp_seg);
        check("digit", digit, exp_dig);
        check("frameTick", frameTick, exp_ft);
    endtask

    // One full frame from a frame boundary, with literal segment values at the
    // first cycle of each position.
    task automatic run_frame_lit(input logic [7:0] s0, input logic [7:0] s1,
                                 input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] lit [4];
        lit[0] = s0; lit[1] = s1; lit[2] = s2; lit[3] = s3;
        for (int k = 0; k < 64; k++) begin
            step();
            if (k % 16 == 0) check("frame_literal", segment, lit[k / 16]);
        end
    endtask

    initial begin
        int sel;
        font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        #1 notReset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_segment", segment, 8'hFF);
        check("reset_digit", digit, 4'hF);
        check("reset_frameTick", frameTick, 1'b0);

        data = 16'h12AF; dpMask = 4'h0; brightness = 2'd3; enable = 1'b1;
        @(negedge clock) notReset = 1'b1;
        cyc = 0;

        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 64; k++) begin
                step();
                if (k % 16 == 0) begin
                    case (k / 16)
                        0: check("scan_pos0", {digit, segment}, {4'b1110, 8'h8E});
                        1: check("scan_pos1", {digit, segment}, {4'b1101, 8'h88});
                        2: check("scan_pos2", {digit, segment}, {4'b1011, 8'hA4});
                        default: check("scan_pos3", {digit, segment}, {4'b0111, 8'hF9});
                    endcase
                end
            end
        end

        brightness = 2'd0;
        sel = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            if (digit != 4'hF) sel++;
        end
        check("dim_selected_cycles", sel, 16);

        brightness = 2'd3; data = 16'h0005; blankLeadingZeros = 1'b1;
        run_frame_lit(8'h92, 8'hFF, 8'hFF, 8'hFF);
        dpMask = 4'b0100;
        run_frame_lit(8'h92, 8'hFF, 8'h7F, 8'hFF);
        data = 16'h0000;
        run_frame_lit(8'hC0, 8'hFF, 8'h7F, 8'hFF);

        dpMask = 4'h0; data = 16'h1111;
        run_frame_lit(8'hF9, 8'hF9, 8'hF9, 8'hF9);
        for (int k = 0; k < 64; k++) begin
            step();
            if (k == 19) data = 16'h2222;
            if (k == 32 || k == 48) check("no_tearing", segment, 8'hF9);
        end
        run_frame_lit(8'hA4, 8'hA4, 8'hA4, 8'hA4);

        for (int k = 0; k < 2000; k++) begin
            step();
            case ($urandom_range(0, 15))
                0: data = 16'($urandom);
                1: data = 16'($urandom_range(0, 255)) << (4 * $urandom_range(0, 2));
                2: dpMask = 4'($urandom);
                3: blankLeadingZeros = 1'($urandom);
                4: brightness = 2'($urandom);
                5: enable = ($urandom_range(0, 3) != 0);
                default: ;
            endcase
        end

        enable = 1'b1; brightness = 2'd3;
        repeat (64) step();
        while (cyc % 64 != 39) step();
        check("pre_reset_digit", digit, 4'b1011);
        #2 notReset = 1'b0;
        #1;
        check("async_reset_segment", segment, 8'hFF);
        check("async_reset_digit", digit, 4'hF);
        check("async_reset_frameTick", frameTick, 1'b0);
        repeat (2) @(posedge clock);
        data = 16'h12AF; dpMask = 4'h0; blankLeadingZeros = 1'b0;
        @(negedge clock) notReset = 1'b1;
        cyc = 0;
        run_frame_lit(8'h8E, 8'h88, 8'hA4, 8'hF9);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised multiplexed seven-segment display driver for devboard bring-up. Successor to the fixed 4-digit scanner and the free-running prescaler in the devboard top level.
- Adds:
  - generic digit count
  - internal refresh timing
  - frame-synchronous data capture (no tearing)
  - per-digit decimal points
  - leading-zero blanking
  - PWM brightness
  - selectable pin polarity
- Sits between core debug/port outputs and the board's segment/digit pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- DIGIT_PERIOD_LOG2, 17, log2 of clock cycles each digit is selected. Must be >= BRIGHTNESS_BITS.
- BRIGHTNESS_BITS, 4, width of the brightness control.
- SEGMENT_ACTIVE_LOW, 1, 1 = segment pins drive 0 to light.
- DIGIT_ACTIVE_LOW, 1, 1 = digit pins drive 0 to select.

Ports:
- clock  input  1  system clock
- notReset  input  1  asynchronous active-low reset
- enable  input  1  0 = all digits deselected; scanning continues
- data  input  4*NUM_DIGITS  hex nibbles; position i = data[4i+3:4i]; position 0 is least significant (rightmost)
- dpMask  input  NUM_DIGITS  decimal point on for position i
- blankLeadingZeros  input  1  suppress leading zero digits
- brightness  input  BRIGHTNESS_BITS  duty control; all-ones = 100%
- segment  output  8  [0]=a … [6]=g, [7]=dp, polarity per SEGMENT_ACTIVE_LOW
- digit  output  NUM_DIGITS  one-hot position select, polarity per DIGIT_ACTIVE_LOW
- frameTick  output  1  one-cycle pulse when a new frame's inputs are captured

Behaviour:
- Reset (notReset low, asynchronous):
  - tickCount=0, position=0, shadow registers=0, frameTick=0.
  - segment = all unlit, i.e. 8'hFF when SEGMENT_ACTIVE_LOW.
  - digit = all deselected, i.e. all ones when DIGIT_ACTIVE_LOW.
  - Takes effect immediately, including mid-scan.
- Counters:
  - tickCount (DIGIT_PERIOD_LOG2 bits) increments every clock and wraps naturally.
  - On wrap, position increments; NUM_DIGITS-1 wraps to 0. Scan order is 0,1,…,N-1.
- Frame capture:
  - Frame start is the cycle with tickCount==0 and position==0, which includes the first clock after reset release.
  - On that cycle data, dpMask, blankLeadingZeros and brightness load into shadow registers and frameTick=1.
  - The load-cycle output uses the newly captured values directly.
  - Input changes at any other time have no visible effect until the next frame start.
- Decode: hex font, active-high a–g.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Inverted when SEGMENT_ACTIVE_LOW.
- Leading-zero blanking: position i (i>0) is blanked when the shadowed blankLeadingZeros=1 and every shadow nibble at positions >= i is 0.
  - Blanked positions drive a–g unlit.
  - dp still follows dpMask.
  - Position 0 is never blanked.
- PWM: phase = tickCount[DIGIT_PERIOD_LOG2-1 : DIGIT_PERIOD_LOG2-BRIGHTNESS_BITS].
  - The current digit is selected only when enable=1 and phase <= shadow brightness.
  - Otherwise all digits are deselected and segments unlit.
  - Duty = (brightness+1)/2^BRIGHTNESS_BITS.
- Outputs are registered. Pins at cycle t+1 reflect counter/shadow state at cycle t: one-cycle latency, glitch-free.
- Exactly zero or one digit is selected in any cycle.
- enable low→high does not reset counters; the display resumes at the current position.

Test Plan:
- Parameters for all scenarios: NUM_DIGITS=4, DIGIT_PERIOD_LOG2=4, BRIGHTNESS_BITS=2, both polarities active-low.
- Reset: hold notReset=0 -> segment=8'hFF, digit=4'hF, frameTick=0. Release -> frameTick pulses on the first clock.
- Scan: data=16'h12AF, dpMask=0, brightness=3, enable=1. Expect each position for 16 cycles:
  - digit=4'b1110 with segment=8'h8E
  - then 4'b1101 with 8'h88
  - then 4'b1011 with 8'hA4
  - then 4'b0111 with 8'hF9
  - Repeats every 64 cycles.
- Brightness: brightness=0 -> each digit is selected only for tickCount 0..3 (4 of 16 cycles); digit=4'hF and segment=8'hFF for the other 12.
- Blanking:
  - data=16'h0005, blankLeadingZeros=1 -> positions 3,2,1 show segment=8'hFF; position 0 shows 8'h92.
  - Add dpMask=4'b0100 -> position 2 shows 8'h7F.
  - data=0 -> position 0 shows 8'hC0.
- Tearing: change data from 16'h1111 to 16'h2222 while position=1 -> positions 1..3 still show '1' (8'hF9). '2' (8'hA4) appears only after the next frameTick.
- Mid-scan reset: assert notReset=0 at position 2, tickCount 7 -> outputs go inactive in the same cycle, without a clock edge. After release the scan restarts at position 0 with a frameTick.
